// File: rtl/voting_pkg.sv
// Shared types and default sizing for the four-candidate voting machine.
// Counter overflow behaviour is selected in voting_machine via VOTE_SATURATE_EN.
package voting_pkg;

    localparam int NUM_CAND        = 4;
    localparam int DEBOUNCE_CYCLES = 10;
    localparam int CNT_W           = 8;
    localparam int ACK_CYCLES      = 10;

    typedef logic [1:0]       cand_idx_t;
    typedef logic [CNT_W-1:0] vote_cnt_t;

    // Index of the lowest-numbered set bit (button1 has the highest priority).
    // Returns 0 when nothing is set; callers qualify with a reduction-OR.
    function automatic cand_idx_t first_high(input logic [NUM_CAND-1:0] bits);
        cand_idx_t idx;
        idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = cand_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Per-button debouncer: counts consecutive high samples and emits one pulse per press
// on the edge where the count reaches DEBOUNCE_CYCLES.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = voting_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic valid_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!btn_in) begin
            cnt <= '0;
        end else if (cnt != FULL) begin
            cnt <= cnt + CW'(1);
        end
    end

    // High during the cycle whose closing edge moves the count from LAST to FULL;
    // saturation at FULL keeps a long hold from firing again.
    assign valid_pulse = btn_in && (cnt == LAST);

endmodule

// File: rtl/voting_machine.sv
// Four-candidate voting core: debounced votes in mode 0, per-candidate count display in mode 1.
// Define VOTE_SATURATE_EN to make vote counters stick at their maximum instead of wrapping.
module voting_machine #(
    parameter int DEBOUNCE_CYCLES = voting_pkg::DEBOUNCE_CYCLES,
    parameter int ACK_CYCLES      = voting_pkg::ACK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode,
    input  logic                          button1,
    input  logic                          button2,
    input  logic                          button3,
    input  logic                          button4,
    output logic [voting_pkg::CNT_W-1:0]  led
);

    localparam int NC = voting_pkg::NUM_CAND;
    localparam int AW = $clog2(ACK_CYCLES + 1);
    localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_CYCLES);

    logic [NC-1:0]          btn;
    logic [NC-1:0]          valid;
    voting_pkg::vote_cnt_t  votes [NC];
    voting_pkg::cand_idx_t  vote_idx;
    voting_pkg::cand_idx_t  show_idx;
    logic                   accept;
    logic [AW-1:0]          ack;
    logic [AW-1:0]          ack_next;

    assign btn = {button4, button3, button2, button1};

    for (genvar g = 0; g < NC; g++) begin : g_deb
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk         (clk),
            .reset       (reset),
            .btn_in      (btn[g]),
            .valid_pulse (valid[g])
        );
    end

    // A pulse implies its own button is high, so btn == valid means every other button is low.
    assign accept   = !mode && $onehot(valid) && (btn == valid);
    assign vote_idx = voting_pkg::first_high(valid);
    assign show_idx = voting_pkg::first_high(btn);

    function automatic voting_pkg::vote_cnt_t next_count(input voting_pkg::vote_cnt_t cur);
`ifdef VOTE_SATURATE_EN
        return (cur == '1) ? cur : cur + voting_pkg::vote_cnt_t'(1);
`else
        return cur + voting_pkg::vote_cnt_t'(1);
`endif
    endfunction

    always_comb begin
        ack_next = ack;
        if (mode) begin
            ack_next = '0;
        end else if (accept) begin
            ack_next = ACK_LOAD;
        end else if (ack != '0) begin
            ack_next = ack - AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                votes[i] <= '0;
            end
            ack <= '0;
            led <= '0;
        end else begin
            if (accept) begin
                votes[vote_idx] <= next_count(votes[vote_idx]);
            end
            ack <= ack_next;
            // The LED follows the post-edge ack value so a vote lights it on the accepting edge.
            if (mode) begin
                led <= (|btn) ? votes[show_idx] : '0;
            end else begin
                led <= (ack_next != '0) ? '1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_voting_machine.sv
// Bench for voting_machine: directed scenarios plus random button traffic, checked
// cycle by cycle against a run-length / vote-tally reference model.
module tb_voting_machine;
    import voting_pkg::*;

    localparam int D = DEBOUNCE_CYCLES;
    localparam int A = ACK_CYCLES;
    localparam int W = CNT_W;

    typedef struct packed {
        logic [3:0] b;
        logic       m;
        logic       r;
    } step_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mode = 1'b0;
    logic         button1 = 1'b0;
    logic         button2 = 1'b0;
    logic         button3 = 1'b0;
    logic         button4 = 1'b0;
    logic [W-1:0] led;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    step_t        stim_q[$];
    logic [W-1:0] got;

    int run_len [4];
    int votes   [4];
    int ack_left;

    always #5 clk = ~clk;

    voting_machine dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .button1 (button1),
        .button2 (button2),
        .button3 (button3),
        .button4 (button4),
        .led     (led)
    );

    // Reference model: one call per rising edge with the inputs sampled on it.
    function automatic void model_step(input logic [3:0] b, input logic m, input logic r);
        int fired_n = 0;
        int fired_i = 0;
        int high_n = 0;
        logic [W-1:0] e = '0;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                run_len[i] = 0;
                votes[i] = 0;
            end
            ack_left = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                run_len[i] = b[i] ? run_len[i] + 1 : 0;
                if (run_len[i] == D) begin
                    fired_n++;
                    fired_i = i;
                end
                if (b[i]) high_n++;
            end
            if (m) begin
                ack_left = 0;
                for (int i = 3; i >= 0; i--) begin
                    if (b[i]) e = W'(votes[i]);
                end
            end else begin
                if (fired_n == 1 && high_n == 1) begin
`ifdef VOTE_SATURATE_EN
                    if (votes[fired_i] < (1 << W) - 1) votes[fired_i]++;
`else
                    votes[fired_i] = (votes[fired_i] + 1) % (1 << W);
`endif
                    ack_left = A;
                end else if (ack_left > 0) begin
                    ack_left--;
                end
                e = (ack_left > 0) ? {W{1'b1}} : '0;
            end
        end
        exp_q.push_back(e);
    endfunction

    function automatic void push_steps(input logic [3:0] b, input logic m, input logic r, input int n);
        step_t s;
        s.b = b;
        s.m = m;
        s.r = r;
        repeat (n) stim_q.push_back(s);
    endfunction

    task automatic tick(input step_t s);
        @(negedge clk);
        {button4, button3, button2, button1} = s.b;
        mode  = s.m;
        reset = s.r;
        @(posedge clk);
        model_step(s.b, s.m, s.r);
        #1 got = led;
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        for (int i = 0; i < 10; i++) begin
            push_steps(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1);
        end
        push_steps(4'b0001, 1'b1, 1'b1, 2);
        push_steps(4'b0010, 1'b1, 1'b1, 2);
        push_steps(4'b0100, 1'b1, 1'b1, 2);
        push_steps(4'b1000, 1'b1, 1'b1, 2);
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset: led=%h expected=%h", got, e);
            end
        end
    endtask

    task automatic test_debounce();
        logic [W-1:0] e;
        int ff_seen = 0;
        push_steps(4'b0000, 1'b0, 1'b0, 2);
        push_steps(4'b0001, 1'b0, 1'b1, 1);
        push_steps(4'b0000, 1'b0, 1'b1, 1);
        push_steps(4'b0001, 1'b0, 1'b1, 20);
        push_steps(4'b0000, 1'b0, 1'b1, 12);
        push_steps(4'b0001, 1'b1, 1'b1, 2);
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front();
            if (mode == 1'b0 && got === {W{1'b1}}) ff_seen++;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL debounce: led=%h expected=%h", got, e);
            end
        end
        checks++;
        if (ff_seen != A) begin
            errors++;
            $display("FAIL debounce_ack_len: ff_cycles=%0d expected=%0d", ff_seen, A);
        end
        checks++;
        if (got !== W'(1)) begin
            errors++;
            $display("FAIL debounce_count: led=%h expected=%h", got, W'(1));
        end
    endtask

    task automatic test_normal_vote();
        logic [W-1:0] e;
        push_steps(4'b0000, 1'b0, 1'b0, 2);
        push_steps(4'b0010, 1'b0, 1'b1, 20);
        push_steps(4'b0010, 1'b1, 1'b1, 3);
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL normal_vote: led=%h expected=%h", got, e);
            end
        end
        checks++;
        if (got !== W'(1)) begin
            errors++;
            $display("FAIL normal_vote_count: led=%h expected=%h", got, W'(1));
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] e;
        int ff_seen = 0;
        push_steps(4'b0000, 1'b0, 1'b0, 2);
        push_steps(4'b0110, 1'b0, 1'b1, 20);
        push_steps(4'b0000, 1'b0, 1'b1, 2);
        push_steps(4'b0010, 1'b1, 1'b1, 2);
        push_steps(4'b0100, 1'b1, 1'b1, 2);
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front();
            if (got !== '0) ff_seen++;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL simultaneous: led=%h expected=%h", got, e);
            end
        end
        checks++;
        if (ff_seen != 0) begin
            errors++;
            $display("FAIL simultaneous_quiet: nonzero_cycles=%0d expected=0", ff_seen);
        end
    endtask

    task automatic test_result_press();
        logic [W-1:0] e;
        push_steps(4'b0000, 1'b0, 1'b0, 2);
        push_steps(4'b0100, 1'b1, 1'b1, 20);
        push_steps(4'b0100, 1'b0, 1'b1, 5);
        push_steps(4'b0000, 1'b0, 1'b1, 2);
        push_steps(4'b0100, 1'b0, 1'b1, 15);
        push_steps(4'b0000, 1'b0, 1'b1, 12);
        push_steps(4'b0100, 1'b1, 1'b1, 2);
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL result_press: led=%h expected=%h", got, e);
            end
        end
        checks++;
        if (got !== W'(1)) begin
            errors++;
            $display("FAIL result_press_count: led=%h expected=%h", got, W'(1));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        logic [3:0] b;
        push_steps(4'b0000, 1'b0, 1'b0, 2);
        for (int seg = 0; seg < 80; seg++) begin
            int kind = $urandom_range(0, 9);
            if (kind < 6) b = 4'(1 << $urandom_range(0, 3));
            else if (kind < 8) b = 4'($urandom_range(0, 15));
            else b = 4'b0000;
            push_steps(b, ($urandom_range(0, 4) == 0), 1'b1, $urandom_range(1, 16));
            push_steps(4'b0000, 1'b0, 1'b1, $urandom_range(0, 3));
        end
        for (int i = 0; i < 4; i++) push_steps(4'(1 << i), 1'b1, 1'b1, 1);
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL random: b=%b mode=%b led=%h expected=%h",
                         {button4, button3, button2, button1}, mode, got, e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] e;
        logic [W-1:0] want;
`ifdef VOTE_SATURATE_EN
        want = {W{1'b1}};
`else
        want = '0;
`endif
        push_steps(4'b0000, 1'b0, 1'b0, 2);
        for (int p = 0; p < (1 << W); p++) begin
            push_steps(4'b1000, 1'b0, 1'b1, D);
            push_steps(4'b0000, 1'b0, 1'b1, 1);
        end
        push_steps(4'b1000, 1'b1, 1'b1, 2);
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL overflow: led=%h expected=%h", got, e);
            end
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL overflow_final: led=%h expected=%h", got, want);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            run_len[i] = 0;
            votes[i] = 0;
        end
        ack_left = 0;
        test_reset();
        test_debounce();
        test_normal_vote();
        test_simultaneous();
        test_result_press();
        test_random();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
